// File: rtl/mtimer_trap_ctrl.sv
// rtl/mtimer_trap_ctrl.sv - machine-mode timer interrupt controller with trap/mret sequencing
//
// Owns the timer-related machine CSRs, drives the MTime_Interrupter compare
// interface, and sequences trap entry and mret return through a redirect
// handshake with the pipeline.
//
// Optional feature macro: MTVEC_VECTORED_EN
//   defined   : mtvec mode 2'b01 vectors the timer trap to base + 28
//   undefined : mtvec[1:0] hardwired to 0, target is always base
//
// Ports:
//   clock, reset                rising-edge clock, async active-high reset
//   mtip, mtime                 pending flag and count from the timer
//   timer_mtie                  interrupt enable to timer (mie.MTIE)
//   timer_load, timer_mtimecmp  one-cycle compare-load strobe and held compare value
//   csr_we/addr/wdata, csr_rdata  CSR write port and combinational read data
//   instr_valid, pc             instruction boundary and next PC
//   mret                        mret retiring this cycle
//   redirect_valid/pc/ack       fetch redirect handshake
module mtimer_trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mtip,
  input  logic [XLEN-1:0] mtime,
  output logic            timer_mtie,
  output logic            timer_load,
  output logic [XLEN-1:0] timer_mtimecmp,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            mret,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ack
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MTIMECMP = 12'h7C0;
  localparam logic [11:0] ADDR_TIME     = 12'hC01;

  // Interrupt bit set, exception code 7 (machine timer interrupt).
  localparam logic [XLEN-1:0] MCAUSE_MTI = {1'b1, {(XLEN-4){1'b0}}, 3'd7};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_HANDLER,
    ST_RETURN
  } state_t;

  state_t          state;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_mtie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;

  logic            take;
  logic            mret_ok;
  logic            csr_wr;
  logic [XLEN-1:0] mtvec_wval;
  logic [XLEN-1:0] trap_target;

`ifdef MTVEC_VECTORED_EN
  localparam logic [XLEN-1:0] MTVEC_INIT = MTVEC_RESET;
  assign mtvec_wval  = csr_wdata;
  // Only mode 2'b01 vectors; reserved modes fall back to the base address.
  assign trap_target = (mtvec[1:0] == 2'b01) ? ({mtvec[XLEN-1:2], 2'b00} + XLEN'(28))
                                             : {mtvec[XLEN-1:2], 2'b00};
`else
  localparam logic [XLEN-1:0] MTVEC_INIT = {MTVEC_RESET[XLEN-1:2], 2'b00};
  assign mtvec_wval  = {csr_wdata[XLEN-1:2], 2'b00};
  assign trap_target = {mtvec[XLEN-1:2], 2'b00};
`endif

  assign timer_mtie = mie_mtie;

  // Interrupts are only sampled while no redirect or handler is in flight.
  assign take    = (state == ST_IDLE) & instr_valid & mtip & mstatus_mie & mie_mtie;
  // A trap in the same cycle pre-empts both mret and any CSR write.
  assign mret_ok = mret & ~take & ((state == ST_IDLE) | (state == ST_HANDLER));
  assign csr_wr  = csr_we & ~take;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[3] = mstatus_mie;
        csr_rdata[7] = mstatus_mpie;
      end
      ADDR_MIE:      csr_rdata[7] = mie_mtie;
      ADDR_MIP:      csr_rdata[7] = mtip;
      ADDR_MTVEC:    csr_rdata    = mtvec;
      ADDR_MEPC:     csr_rdata    = mepc;
      ADDR_MCAUSE:   csr_rdata    = mcause;
      ADDR_MTIMECMP: csr_rdata    = timer_mtimecmp;
      ADDR_TIME:     csr_rdata    = mtime;
      default:       csr_rdata    = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      mstatus_mie    <= 1'b0;
      mstatus_mpie   <= 1'b0;
      mie_mtie       <= 1'b0;
      mtvec          <= MTVEC_INIT;
      mepc           <= '0;
      mcause         <= '0;
      timer_mtimecmp <= '1;
      timer_load     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      timer_load <= 1'b0;

      if (csr_wr) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
          end
          ADDR_MIE:    mie_mtie <= csr_wdata[7];
          ADDR_MTVEC:  mtvec    <= mtvec_wval;
          ADDR_MEPC:   mepc     <= {csr_wdata[XLEN-1:2], 2'b00};
          ADDR_MCAUSE: mcause   <= csr_wdata;
          ADDR_MTIMECMP: begin
            timer_mtimecmp <= csr_wdata;
            timer_load     <= 1'b1;
          end
          default: ;
        endcase
      end

      // Placed after the CSR write so mret's mstatus update wins over a
      // simultaneous mstatus write.
      if (take) begin
        mepc           <= {pc[XLEN-1:2], 2'b00};
        mcause         <= MCAUSE_MTI;
        mstatus_mpie   <= mstatus_mie;
        mstatus_mie    <= 1'b0;
        redirect_pc    <= trap_target;
        redirect_valid <= 1'b1;
        state          <= ST_PENDING;
      end else if (mret_ok) begin
        mstatus_mie    <= mstatus_mpie;
        mstatus_mpie   <= 1'b1;
        redirect_pc    <= mepc;
        redirect_valid <= 1'b1;
        state          <= ST_RETURN;
      end else if (redirect_ack) begin
        redirect_valid <= 1'b0;
        case (state)
          ST_PENDING: state <= ST_HANDLER;
          ST_RETURN:  state <= ST_IDLE;
          default:    state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mtimer_trap_ctrl.sv
// tb/tb_mtimer_trap_ctrl.sv - self-checking bench for mtimer_trap_ctrl
module tb_mtimer_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mtip = 1'b0;
  logic [31:0] mtime = '0;
  logic        timer_mtie;
  logic        timer_load;
  logic [31:0] timer_mtimecmp;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        instr_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        mret = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack = 1'b0;

  mtimer_trap_ctrl #(.XLEN(32), .MTVEC_RESET(32'h0)) dut (
    .clock(clock), .reset(reset), .mtip(mtip), .mtime(mtime),
    .timer_mtie(timer_mtie), .timer_load(timer_load), .timer_mtimecmp(timer_mtimecmp),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .instr_valid(instr_valid), .pc(pc), .mret(mret),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural CSR values as whole words.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_cmp;
  logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                              12'h344, 12'h7C0, 12'hC01, 12'h123, 12'hFFF};

  task automatic model_reset();
    m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_cmp = 32'hFFFF_FFFF;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: m_mstatus = d & 32'h88;
      12'h304: m_mie = d & 32'h80;
`ifdef MTVEC_VECTORED_EN
      12'h305: m_mtvec = d;
`else
      12'h305: m_mtvec = d & ~32'h3;
`endif
      12'h341: m_mepc = d & ~32'h3;
      12'h342: m_mcause = d;
      12'h7C0: m_cmp = d;
      default: ;
    endcase
  endtask

  task automatic model_take(input logic [31:0] p);
    m_mepc = p & ~32'h3;
    m_mcause = 32'h8000_0007;
    m_mstatus = (m_mstatus & 32'h8) != 0 ? 32'h80 : 32'h0;
  endtask

  task automatic model_mret();
    m_mstatus = 32'h80 | (((m_mstatus & 32'h80) != 0) ? 32'h8 : 32'h0);
  endtask

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return mtip ? 32'h80 : 32'h0;
      12'h7C0: return m_cmp;
      12'hC01: return mtime;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_target();
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
`ifdef MTVEC_VECTORED_EN
    if ((m_mtvec & 32'h3) == 32'h1) return base + 32'd28;
`endif
    return base;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic do_take(input logic [31:0] p);
    instr_valid = 1'b1; pc = p;
    tick();
    instr_valid = 1'b0;
    model_take(p);
  endtask

  task automatic do_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    model_mret();
  endtask

  task automatic do_ack();
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mtip = 1'b1; instr_valid = 1'b1; pc = 32'h40;
    model_reset();
    tick(); tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
    checks++; if (timer_load !== 1'b0) begin errors++; $display("FAIL reset_load got=%b exp=0", timer_load); end
    checks++; if (timer_mtie !== 1'b0) begin errors++; $display("FAIL reset_mtie got=%b exp=0", timer_mtie); end
    csr_addr = 12'h7C0; #1;
    checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_mtimecmp got=%h exp=ffffffff", csr_rdata); end
    reset = 1'b0;
    tick();
    // MIE is clear after reset, so a boundary with mtip must not trap.
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_notake got=%b exp=0", redirect_valid); end
    instr_valid = 1'b0; mtip = 1'b0;
    for (int i = 0; i < 8; i++) begin
      csr_addr = addrs[i]; #1;
      checks++; if (csr_rdata !== exp_read(addrs[i])) begin errors++; $display("FAIL reset_csr addr=%h got=%h exp=%h", addrs[i], csr_rdata, exp_read(addrs[i])); end
    end
  endtask

  task automatic test_mtimecmp();
    checks++; if (timer_load !== 1'b0) begin errors++; $display("FAIL load_idle got=%b exp=0", timer_load); end
    csr_write(12'h7C0, 32'hF0);
    checks++; if (timer_load !== 1'b1) begin errors++; $display("FAIL load_pulse got=%b exp=1", timer_load); end
    checks++; if (timer_mtimecmp !== 32'hF0) begin errors++; $display("FAIL cmp_value got=%h exp=f0", timer_mtimecmp); end
    tick();
    checks++; if (timer_load !== 1'b0) begin errors++; $display("FAIL load_one_cycle got=%b exp=0", timer_load); end
    tick();
    checks++; if (timer_mtimecmp !== 32'hF0) begin errors++; $display("FAIL cmp_held got=%h exp=f0", timer_mtimecmp); end
    csr_addr = 12'h7C0; #1;
    checks++; if (csr_rdata !== 32'hF0) begin errors++; $display("FAIL cmp_read got=%h exp=f0", csr_rdata); end
  endtask

  task automatic test_trap();
    csr_write(12'h305, 32'h8000);
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    checks++; if (timer_mtie !== 1'b1) begin errors++; $display("FAIL mtie_out got=%b exp=1", timer_mtie); end
    mtip = 1'b1; instr_valid = 1'b1; pc = 32'h100;
    #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL take_cycle_rvalid got=%b exp=0", redirect_valid); end
    tick();
    instr_valid = 1'b0;
    model_take(32'h100);
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL trap_rvalid got=%b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h8000) begin errors++; $display("FAIL trap_rpc got=%h exp=8000", redirect_pc); end
    csr_addr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h100) begin errors++; $display("FAIL trap_mepc got=%h exp=100", csr_rdata); end
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h8000_0007) begin errors++; $display("FAIL trap_mcause got=%h exp=80000007", csr_rdata); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL trap_mstatus got=%h exp=80", csr_rdata); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000) begin errors++; $display("FAIL hold_stable cyc=%0d got=%b/%h exp=1/8000", i, redirect_valid, redirect_pc); end
    end
    do_ack();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL hold_drop got=%b exp=0", redirect_valid); end
    // Re-enable MIE inside the handler; the controller must still not trap.
    csr_write(12'h300, 32'h88);
    mtip = 1'b1; instr_valid = 1'b1; pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL handler_notake cyc=%0d got=%b exp=0", i, redirect_valid); end
    end
    instr_valid = 1'b0; mtip = 1'b0;
    csr_addr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h100) begin errors++; $display("FAIL handler_mepc got=%h exp=100", csr_rdata); end
  endtask

  task automatic test_mret();
    do_mret();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin errors++; $display("FAIL mret_redirect got=%b/%h exp=1/100", redirect_valid, redirect_pc); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL mret_mstatus got=%h exp=88", csr_rdata); end
    do_ack();  // acked in the same cycle valid rose
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mret_drop got=%b exp=0", redirect_valid); end
    // Back in IDLE: a fresh boundary must trap.
    mtip = 1'b1;
    do_take(32'h204);
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== exp_target()) begin errors++; $display("FAIL idle_retake got=%b/%h exp=1/%h", redirect_valid, redirect_pc, exp_target()); end
    mtip = 1'b0;
    do_ack();
    do_mret();
    checks++; if (redirect_pc !== 32'h204) begin errors++; $display("FAIL retake_mret got=%h exp=204", redirect_pc); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    // take, mret and a CSR write all in one cycle: only the trap happens.
    mtip = 1'b1; mret = 1'b1; csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h4000;
    do_take(32'h300);
    mret = 1'b0; csr_we = 1'b0; mtip = 1'b0;
    checks++; if (redirect_pc !== exp_target()) begin errors++; $display("FAIL b2b_target got=%h exp=%h", redirect_pc, exp_target()); end
    csr_addr = 12'h305; #1;
    checks++; if (csr_rdata !== m_mtvec) begin errors++; $display("FAIL b2b_write_dropped got=%h exp=%h", csr_rdata, m_mtvec); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== m_mstatus) begin errors++; $display("FAIL b2b_mstatus got=%h exp=%h", csr_rdata, m_mstatus); end
    // mret while the trap redirect is pending is ignored.
    mret = 1'b1; tick(); mret = 1'b0;
    checks++; if (redirect_pc !== exp_target() || redirect_valid !== 1'b1) begin errors++; $display("FAIL pending_mret got=%b/%h exp=1/%h", redirect_valid, redirect_pc, exp_target()); end
    do_ack();
    do_mret();
    checks++; if (redirect_pc !== 32'h300) begin errors++; $display("FAIL b2b_return got=%h exp=300", redirect_pc); end
    do_ack();
  endtask

  task automatic test_vectored();
    csr_write(12'h305, 32'h8001);
    csr_addr = 12'h305; #1;
    checks++; if (csr_rdata !== m_mtvec) begin errors++; $display("FAIL mtvec_mode got=%h exp=%h", csr_rdata, m_mtvec); end
    csr_write(12'h300, 32'h8);
    mtip = 1'b1;
    do_take(32'h600);
    mtip = 1'b0;
`ifdef MTVEC_VECTORED_EN
    checks++; if (redirect_pc !== 32'h801C) begin errors++; $display("FAIL vectored_target got=%h exp=801c", redirect_pc); end
`else
    checks++; if (redirect_pc !== 32'h8000) begin errors++; $display("FAIL direct_target got=%h exp=8000", redirect_pc); end
`endif
    do_ack(); do_mret(); do_ack();
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      mtime = $urandom;
      mtip = 1'($urandom_range(0, 1));
      csr_write(addrs[$urandom_range(0, 9)], $urandom);
      for (int i = 0; i < 10; i++) begin
        csr_addr = addrs[i]; #1;
        checks++; if (csr_rdata !== exp_read(addrs[i])) begin errors++; $display("FAIL rand_csr n=%0d addr=%h got=%h exp=%h", n, addrs[i], csr_rdata, exp_read(addrs[i])); end
      end
    end
    for (int n = 0; n < 8; n++) begin
      logic [31:0] p;
      int d;
      p = $urandom;
      d = $urandom_range(0, 3);
      csr_write(12'h305, $urandom);
      csr_write(12'h304, 32'h80);
      csr_write(12'h300, 32'h8);
      mtip = 1'b1;
      do_take(p);
      mtip = 1'($urandom_range(0, 1));
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== exp_target()) begin errors++; $display("FAIL rand_trap n=%0d got=%b/%h exp=1/%h", n, redirect_valid, redirect_pc, exp_target()); end
      csr_addr = 12'h341; #1;
      checks++; if (csr_rdata !== (p & ~32'h3)) begin errors++; $display("FAIL rand_mepc n=%0d got=%h exp=%h", n, csr_rdata, p & ~32'h3); end
      repeat (d) tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== exp_target()) begin errors++; $display("FAIL rand_hold n=%0d got=%b/%h exp=1/%h", n, redirect_valid, redirect_pc, exp_target()); end
      do_ack();
      do_mret();
      checks++; if (redirect_pc !== (p & ~32'h3)) begin errors++; $display("FAIL rand_mret n=%0d got=%h exp=%h", n, redirect_pc, p & ~32'h3); end
      do_ack();
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rand_drop n=%0d got=%b exp=0", n, redirect_valid); end
    end
    mtip = 1'b0;
  endtask

  task automatic test_reset_mid();
    csr_write(12'h300, 32'h8);
    mtip = 1'b1;
    do_take(32'h700);
    mtip = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL async_reset_rvalid got=%b exp=0", redirect_valid); end
    model_reset();
    tick();
    reset = 1'b0;
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL async_reset_mstatus got=%h exp=0", csr_rdata); end
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    mtip = 1'b1;
    do_take(32'h900);
    mtip = 1'b0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== exp_target()) begin errors++; $display("FAIL post_reset_take got=%b/%h exp=1/%h", redirect_valid, redirect_pc, exp_target()); end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_mtimecmp();
    test_trap();
    test_hold();
    test_mret();
    test_back_to_back();
    test_vectored();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mtimer_trap_ctrl.md
# mtimer_trap_ctrl

Machine-mode timer-interrupt controller that sits between the core pipeline and the `MTime_Interrupter` timer block. It drives the timer's `load`/`mtimecmp`/`mtie` inputs and consumes its `mtip`/`mtime` outputs. It also owns the timer-related machine CSRs and sequences trap entry and `mret` return through a redirect handshake with the pipeline.

## Interface
- XLEN, 32, datapath/CSR width; must match the timer's XLEN
- MTVEC_RESET, 0, reset value of mtvec
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mtip  input  1  timer interrupt pending from timer
- mtime  input  XLEN  current timer count
- timer_mtie  output  1  interrupt enable to timer, equals mie.MTIE
- timer_load  output  1  one-cycle compare-load strobe to timer
- timer_mtimecmp  output  XLEN  compare value to timer, held between loads
- csr_we  input  1  CSR write strobe
- csr_addr  input  12  CSR address
- csr_wdata  input  XLEN  CSR write data
- csr_rdata  output  XLEN  CSR read data, combinational on csr_addr
- instr_valid  input  1  instruction boundary; interrupt may be taken this cycle
- pc  input  XLEN  PC of next instruction not yet executed at the boundary
- mret  input  1  mret retiring this cycle
- redirect_valid  output  1  fetch redirect request
- redirect_pc  output  XLEN  redirect target
- redirect_ack  input  1  pipeline accepted redirect

## Operation
- CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7; other bits read 0.
  - mie 0x304: MTIE bit7.
  - mip 0x344: MTIP bit7 = mtip, read-only.
  - mtvec 0x305: bits[1:0] mode, base {[XLEN-1:2],2'b00}.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mtimecmp 0x7C0: read returns timer_mtimecmp.
  - time 0xC01: read-only, returns mtime.
  - Unmapped addresses read 0 and ignore writes.
- A write to 0x7C0 latches timer_mtimecmp and pulses timer_load for exactly one cycle.
- States:
  - IDLE -> PENDING when take = instr_valid & mtip & mstatus.MIE & mie.MTIE.
  - PENDING -> HANDLER on redirect_ack.
  - HANDLER or IDLE -> RETURN on mret.
  - RETURN -> IDLE on redirect_ack.
- On take, the following happen in one edge:
  - mepc <= pc
  - mcause <= {1'b1, (XLEN-1)'d7}
  - MPIE <= MIE
  - MIE <= 0
  - redirect_pc <= trap target
  - redirect_valid <= 1
- On mret (accepted in IDLE or HANDLER only):
  - MIE <= MPIE
  - MPIE <= 1
  - redirect_pc <= mepc
  - redirect_valid <= 1
- mret is ignored in PENDING and RETURN.
- redirect_valid and redirect_pc are held stable until redirect_ack; they drop the cycle after the ack edge.
- Simultaneous events:
  - take and csr_we in the same cycle: the trap wins and the CSR write is discarded.
  - take and mret in the same cycle: take wins.
  - take is never evaluated outside IDLE.

## Timing
- Reset values:
  - mstatus 0, mie 0, mepc 0, mcause 0, mtvec MTVEC_RESET
  - timer_mtimecmp all ones, timer_load 0, timer_mtie 0
  - redirect_valid 0, redirect_pc 0
  - state IDLE
- CSR writes are visible on csr_rdata the cycle after csr_we.
- timer_load is asserted the cycle after the mtimecmp write.
- Interrupt latency: redirect_valid rises one cycle after the take cycle.
- redirect_ack in the same cycle redirect_valid first rises is legal: minimum 1-cycle handshake.
- Reset asserted mid-handshake clears redirect_valid immediately (asynchronous) and returns the FSM to IDLE.

## Configuration
- MTVEC_VECTORED_EN
  - Defined: when mtvec[1:0]==2'b01, trap target = base + 28 (cause 7 × 4). Mode 2'b00 gives base.
  - Undefined: mtvec[1:0] are hardwired to 0 (write-ignored, read 0), and the target is always base.

## Test plan
- Reset with mtip=1 -> redirect_valid=0, csr_rdata for 0x7C0 = 0xFFFF_FFFF, timer_load=0.
- Write 0x7C0 with 0xF0 -> timer_load high for exactly one cycle, timer_mtimecmp=0xF0 held afterwards.
- Set MTIE and MIE; mtip=1; instr_valid with pc=0x100; mtvec=0x8000 -> expected response:
  - redirect_valid next cycle with redirect_pc=0x8000
  - mepc=0x100, mcause=0x8000_0007
  - MIE=0, MPIE=1
- Hold redirect_ack=0 for 5 cycles -> redirect_valid/redirect_pc stable; a second mtip during HANDLER is not taken.
- mret in HANDLER -> redirect_pc=0x100, MIE=1 after ack, FSM back in IDLE.
- With MTVEC_VECTORED_EN and mtvec=0x8001 -> trap target 0x801C.
